// File: rtl/rs_encoder.sv
// Systematic RS(K+16,K) encoder over GF(256)/0x11D, shortened from RS(255,239), roots alpha^0..alpha^15.
// Define RS_ENC_SYNC_CHECK_EN to flag codewords whose first byte is neither 0x47 nor 0xB8 on sync_err_o.
module rs_encoder #(
    parameter int unsigned K = 188
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_valid_i,
    input  logic       in_sop_i,
    input  logic [7:0] in_data_i,
    output logic       in_ready_o,
    output logic       out_valid_o,
    output logic       out_sop_o,
    output logic       out_eop_o,
    output logic [7:0] out_data_o,
    output logic       sync_err_o
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // Expands prod (x + alpha^i) at elaboration; only constant multipliers reach the netlist.
    function automatic logic [16:0][7:0] gen_poly();
        logic [16:0][7:0] g;
        logic [7:0]       root;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int unsigned i = 0; i < 16; i++) begin
            for (int unsigned j = 16; j >= 1; j--) begin
                g[j] = g[j-1] ^ gf_mul(root, g[j]);
            end
            g[0] = gf_mul(root, g[0]);
            root = gf_mul(root, 8'h02);
        end
        return g;
    endfunction

    localparam logic [16:0][7:0] GEN = gen_poly();
    localparam logic [7:0]       K_B = 8'(K);

    state_e           state_q;
    logic [7:0]       cnt_q;
    logic [15:0][7:0] par_q;
    logic [15:0][7:0] par_d;
    logic [15:0][7:0] par_base;
    logic [7:0]       fb;
    logic [7:0]       cnt_d;
    logic             accept;
    logic             out_valid_q;
    logic             out_sop_q;
    logic             out_eop_q;
    logic [7:0]       out_data_q;

    assign in_ready_o = (state_q != PARITY);
    assign accept     = in_valid_i & in_ready_o;
    // A start-of-packet byte always divides from a cleared register, which also covers the abort case.
    assign cnt_d      = in_sop_i ? 8'd1 : cnt_q + 8'd1;

    always_comb begin
        par_base = in_sop_i ? '0 : par_q;
        fb       = in_data_i ^ par_base[15];
        par_d    = '0;
        par_d[0] = gf_mul(fb, GEN[0]);
        for (int unsigned i = 1; i < 16; i++) begin
            par_d[i] = par_base[i-1] ^ gf_mul(fb, GEN[i]);
        end
    end

`ifdef RS_ENC_SYNC_CHECK_EN
    logic sync_err_q;
    assign sync_err_o = sync_err_q;
`else
    assign sync_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            par_q       <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
`ifdef RS_ENC_SYNC_CHECK_EN
            sync_err_q  <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
`ifdef RS_ENC_SYNC_CHECK_EN
            sync_err_q  <= 1'b0;
`endif
            case (state_q)
                IDLE, DATA: begin
                    if (accept && (in_sop_i || state_q == DATA)) begin
                        out_valid_q <= 1'b1;
                        out_sop_q   <= in_sop_i;
                        out_data_q  <= in_data_i;
                        par_q       <= par_d;
`ifdef RS_ENC_SYNC_CHECK_EN
                        sync_err_q  <= in_sop_i && (in_data_i != 8'h47) && (in_data_i != 8'hB8);
`endif
                        if (cnt_d == K_B) begin
                            state_q <= PARITY;
                            cnt_q   <= 8'd1;
                        end else begin
                            state_q <= DATA;
                            cnt_q   <= cnt_d;
                        end
                    end
                end
                PARITY: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= par_q[15];
                    par_q       <= {par_q[14:0], 8'h00};
                    if (cnt_q == 8'd16) begin
                        out_eop_q <= 1'b1;
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sop_o   = out_sop_q;
    assign out_eop_o   = out_eop_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Directed bench for rs_encoder (K=188): known generator table, long-division model and syndrome checks.
module tb_rs_encoder;

    localparam int K = 188;
    localparam int N = K + 16;
`ifdef RS_ENC_SYNC_CHECK_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sop = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, out_valid, out_sop, out_eop, sync_err;
    logic [7:0] out_data;

    always #5 clk = ~clk;

    rs_encoder #(.K(K)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_sop_i(in_sop),
        .in_data_i(in_data), .in_ready_o(in_ready), .out_valid_o(out_valid),
        .out_sop_o(out_sop), .out_eop_o(out_eop), .out_data_o(out_data),
        .sync_err_o(sync_err)
    );

    // DVB generator g0..g16 for roots alpha^0..alpha^15
    logic [7:0] G_TAB [0:16] = '{8'd59, 8'd36, 8'd50, 8'd98, 8'd229, 8'd41, 8'd65, 8'd163,
                                 8'd8, 8'd30, 8'd209, 8'd68, 8'd189, 8'd104, 8'd13, 8'd59, 8'd1};

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    logic [7:0] gexp [0:255];
    int         glog [0:255];
    logic [7:0] msg [0:K-1];
    logic [7:0] exp_par [0:15];

    logic [7:0] oq[$];
    bit         sq[$], eq[$], yq[$];
    int         cq[$];
    int         run = 0, max_run = 0, rdy_low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                oq.push_back(out_data); sq.push_back(out_sop); eq.push_back(out_eop);
                yq.push_back(sync_err); cq.push_back(cyc);
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (!in_ready) rdy_low++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic clear_mon();
        oq.delete(); sq.delete(); eq.delete(); yq.delete(); cq.delete();
        run = 0; max_run = 0; rdy_low = 0;
    endtask

    task automatic push(input logic [7:0] d, input logic s);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_sop = s;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("push_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        in_valid = 1'b0; in_sop = 1'b0;
    endtask

    task automatic send(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                @(posedge clk);
                #1;
            end
            push(msg[i], i == 0);
        end
    endtask

    task automatic wait_out(input int n);
        int g = 0;
        while (oq.size() < n && g < 3000) begin
            @(negedge clk); #1;
            g++;
        end
        repeat (3) @(negedge clk);
        #1;
        check("out_count", oq.size(), n);
    endtask

    task automatic model_parity();
        logic [7:0] w [0:N-1];
        logic [7:0] c;
        for (int i = 0; i < N; i++) w[i] = (i < K) ? msg[i] : 8'h00;
        for (int i = 0; i < K; i++) begin
            c = w[i];
            for (int j = 1; j <= 16; j++) w[i+j] = w[i+j] ^ gmul(c, G_TAB[16-j]);
        end
        for (int j = 0; j < 16; j++) exp_par[j] = w[K+j];
    endtask

    task automatic check_frame(input int off);
        int mism = 0;
        logic [7:0] s;
        model_parity();
        if (oq.size() < off + N) begin
            check("frame_short", oq.size(), off + N);
            return;
        end
        for (int i = 0; i < K; i++) if (oq[off+i] !== msg[i]) mism++;
        check("data_mismatches", mism, 0);
        for (int j = 0; j < 16; j++) check($sformatf("parity[%0d]", j), oq[off+K+j], exp_par[j]);
        for (int r = 0; r < 16; r++) begin
            s = 8'h00;
            for (int k = 0; k < N; k++) s = gmul(s, gexp[r]) ^ oq[off+k];
            check($sformatf("syndrome[%0d]", r), s, 0);
        end
    endtask

    function automatic int count_bits(input int which);
        int c = 0;
        for (int i = 0; i < oq.size(); i++) begin
            if (which == 0 && sq[i]) c++;
            if (which == 1 && eq[i]) c++;
            if (which == 2 && yq[i] && !sq[i]) c++;
        end
        return c;
    endfunction

    initial begin
        int x = 1;
        int g;
        int nz;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = 8'(x);
            glog[x] = i;
            x = x << 1;
            if (x > 255) x = x ^ 'h11D;
        end
        gexp[255] = gexp[0];
        glog[0] = 0;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("ready_in_reset", in_ready, 1);
        check("valid_in_reset", out_valid, 0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check("rst_valid", out_valid, 0);
        check("rst_sop", out_sop, 0);
        check("rst_eop", out_eop, 0);
        check("rst_data", out_data, 0);
        check("rst_sync", sync_err, 0);
        check("rst_ready", in_ready, 1);

        // bytes without sop in IDLE are dropped
        clear_mon();
        push(8'h55, 1'b0); push(8'h47, 1'b0);
        repeat (4) @(negedge clk);
        #1;
        check("idle_discard", oq.size(), 0);

        // all-zero codeword
        clear_mon();
        for (int i = 0; i < K; i++) msg[i] = 8'h00;
        send(K, 1'b0);
        wait_out(N);
        nz = 0;
        for (int i = 0; i < oq.size(); i++) if (oq[i] != 8'h00) nz++;
        check("zero_nonzero_bytes", nz, 0);
        check("zero_eop_last", eq[N-1], 1);
        check("zero_eop_count", count_bits(1), 1);
        check("zero_sop_first", sq[0], 1);
        check("zero_sop_count", count_bits(0), 1);
        check("zero_sync", yq[0], SYNC_EN);

        // impulse: parity equals generator coefficients g15..g0
        clear_mon();
        msg[K-1] = 8'h01;
        send(K, 1'b0);
        wait_out(N);
        for (int j = 0; j < 16; j++) check($sformatf("impulse[%0d]", j), oq[K+j], G_TAB[15-j]);
        check("lat_data", cq[K-1] - acc_cyc, 0);
        check("lat_parity1", cq[K] - acc_cyc, 1);
        check("lat_eop", cq[N-1] - acc_cyc, 16);
        check("ready_low_one", rdy_low, 16);

        // random codeword, ~50% in_valid gaps, bad sync byte
        clear_mon();
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        msg[0] = 8'h12;
        send(K, 1'b1);
        wait_out(N);
        check_frame(0);
        check("sync_bad", yq[0], SYNC_EN);
        check("sync_only_sop", count_bits(2), 0);

        // back-to-back codewords with in_valid held high
        clear_mon();
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        msg[0] = 8'h47;
        send(K, 1'b0);
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        msg[0] = 8'hB8;
        send(K, 1'b0);
        wait_out(2 * N);
        check("b2b_run", max_run, 2 * N);
        check("b2b_ready_low", rdy_low, 32);
        check("b2b_sync0", yq[0], 0);
        check("b2b_sync1", yq[N], 0);
        check_frame(N);

        // sop reasserted at data byte 100 aborts the first frame
        clear_mon();
        for (int i = 0; i < 99; i++) push(8'($urandom), i == 0);
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        send(K, 1'b0);
        wait_out(99 + N);
        check("abort_sop2", sq[99], 1);
        check("abort_sop_count", count_bits(0), 2);
        check("abort_eop_count", count_bits(1), 1);
        check_frame(99);

        // asynchronous reset during parity byte 5
        clear_mon();
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom) | 8'h01;
        send(K, 1'b0);
        g = 0;
        while (oq.size() < K + 5 && g < 3000) begin
            @(negedge clk); #1;
            g++;
        end
        check("pre_rst_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_sop", out_sop, 0);
        check("arst_eop", out_eop, 0);
        check("arst_data", out_data, 0);
        check("arst_sync", sync_err, 0);
        check("arst_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        push(8'h33, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        check("post_rst_discard", oq.size(), 0);
        for (int i = 0; i < K; i++) msg[i] = 8'($urandom);
        send(K, 1'b1);
        wait_out(N);
        check_frame(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rs_encoder.md
RS_ENCODER -- requirements
Module: rs_encoder

Interface
REQ-001 Parameter K, default 188, data bytes per codeword (legal 1..239); codeword length is K+16.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_data/in_sop valid this cycle.
REQ-005 in_sop  input  1  marks first data byte of a codeword.
REQ-006 in_data  input  8  message byte, GF(256) symbol.
REQ-007 in_ready  output  1  encoder accepts a byte this cycle.
REQ-008 out_valid  output  1  out_data valid this cycle.
REQ-009 out_sop  output  1  first byte of output codeword.
REQ-010 out_eop  output  1  last (16th) parity byte.
REQ-011 out_data  output  8  systematic codeword byte.
REQ-012 sync_err  output  1  one-cycle flag for a bad sync byte; tied 0 unless RS_ENC_SYNC_CHECK_EN is defined.

Function
REQ-013 The encoder SHALL compute the systematic RS(K+16,K) code shortened from RS(255,239).
- Field polynomial: x^8+x^4+x^3+x^2+1 (0x11D).
- Generator: g(x)=prod_{i=0..15}(x+alpha^i), alpha=0x02.
REQ-014 Acceptance: a byte is accepted iff in_valid and in_ready are both 1.
REQ-015 in_ready SHALL be 1 in IDLE and DATA, and 0 in PARITY.
REQ-016 FSM states and transitions:
- IDLE->DATA on an accepted byte with in_sop=1.
- DATA->PARITY on acceptance of data byte K.
- PARITY->IDLE after the 16th parity byte is emitted.
REQ-017 Parity register: 16x8-bit LFSR division register.
- On each accepted data byte, feedback fb=in_data^r15.
- Update: r_i <= r_(i-1)^(fb*g_i), r0 <= fb*g0.
- Multipliers are constant GF multipliers.
REQ-018 Data path: each accepted data byte SHALL appear on out_data with out_valid=1 exactly one cycle after acceptance (registered output).
REQ-019 Parity path: in each PARITY cycle, out_data <= r15 and the register shifts up with zero fill.
- Last data byte accepted at cycle t: parity bytes appear at t+2..t+17, highest-order first.
- out_eop=1 at t+17.
- in_ready returns to 1 at t+17.
REQ-020 A new in_sop accepted at t+17 SHALL produce its first byte at t+18 (gap-free back-to-back codewords).
REQ-021 out_sop SHALL be 1 only with the output copy of the byte accepted with in_sop=1.
REQ-022 in_valid gaps in DATA SHALL hold byte count and parity register, with out_valid=0 in the following cycle.
REQ-023 Accepted bytes in IDLE with in_sop=0 SHALL be discarded, with no output and no state change.
REQ-024 An accepted in_sop=1 while in DATA SHALL abort the current codeword:
- no parity emitted for it;
- parity register cleared, byte counter restarted at 1;
- the new byte is encoded as byte 1 of a new codeword.
REQ-025 Byte counter SHALL be 8 bits, counting 1..K in DATA and 1..16 in PARITY, and never wrap.

Reset
REQ-026 Reset=0 SHALL asynchronously force the following, regardless of the current state (including mid-DATA or mid-PARITY):
- state IDLE, parity register 0, counter 0;
- out_valid=0, out_sop=0, out_eop=0, out_data=0x00, sync_err=0.
REQ-027 in_ready SHALL be 1 during and after reset.
REQ-028 After Reset rises, the first acceptable byte is one with in_sop=1.

Configuration
REQ-029 With RS_ENC_SYNC_CHECK_EN defined:
- sync_err=1 for one cycle, aligned with out_sop, when the in_sop byte is neither 0x47 nor 0xB8;
- encoding is unaffected.
REQ-030 Without RS_ENC_SYNC_CHECK_EN, sync_err SHALL be constant 0 and no comparison logic is built.

Verification
REQ-031 All-zero codeword: K=188 bytes of 0x00 -> 188 zeros followed by 16 parity bytes of 0x00; out_eop on output byte 204.
REQ-032 Impulse: 187 x 0x00 then 0x01 -> parity bytes equal g15..g0 in order; check against reference-model coefficients.
REQ-033 Random codeword with in_valid toggled 50%:
- output data matches input;
- parity matches software RS(204,188) model;
- the 204-byte codeword has syndromes S0..S15 all zero.
REQ-034 Two codewords back-to-back with in_valid held high -> 408 consecutive out_valid cycles, in_ready low exactly 16 cycles per codeword.
REQ-035 in_sop reasserted at data byte 100 -> first frame truncated at 99 output bytes with no parity; second frame parity correct.
REQ-036 Reset pulled low at parity byte 5 -> all outputs 0 within the same cycle, in_ready=1.
- With RS_ENC_SYNC_CHECK_EN: first byte 0x12 -> sync_err=1 with out_sop.
- With RS_ENC_SYNC_CHECK_EN: first byte 0x47 -> sync_err=0.
